// File: rtl/pe_result_deskew.sv
// De-skews staggered per-column systolic array results into row-aligned vectors
// and drains them one row per valid/ready handshake.
module pe_result_deskew #(
    parameter int ARRAY_SIZE             = 8,
    parameter int ARRAY_SIZE_WIDTH       = $clog2(ARRAY_SIZE),
    parameter int ACCUMULATOR_DATA_WIDTH = 16
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic signed [ACCUMULATOR_DATA_WIDTH-1:0] results_in [ARRAY_SIZE],
    output logic signed [ACCUMULATOR_DATA_WIDTH-1:0] row_data   [ARRAY_SIZE],
    output logic        [ARRAY_SIZE_WIDTH-1:0]       row_idx,
    output logic                                     row_valid,
    input  logic                                     row_ready,
    output logic                                     busy,
    output logic                                     done
);

    localparam int TW = ($clog2(2 * ARRAY_SIZE - 1) < 1) ? 1 : $clog2(2 * ARRAY_SIZE - 1);
    localparam logic [TW-1:0]               TLAST = TW'(2 * ARRAY_SIZE - 2);
    localparam logic [ARRAY_SIZE_WIDTH-1:0] RLAST = ARRAY_SIZE_WIDTH'(ARRAY_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DRAIN
    } state_t;

    state_t                                   state_q, state_d;
    logic        [TW-1:0]                     t_q, t_d;
    logic        [ARRAY_SIZE_WIDTH-1:0]       row_idx_q, row_idx_d;
    logic                                     done_q, done_d;
    logic signed [ACCUMULATOR_DATA_WIDTH-1:0] rowbuf_q [ARRAY_SIZE][ARRAY_SIZE];

    logic                                     cap_en;
    logic        [TW-1:0]                     cap_t;
    logic                                     lane_en  [ARRAY_SIZE];
    logic        [ARRAY_SIZE_WIDTH-1:0]       lane_row [ARRAY_SIZE];

    // The start edge itself is capture step t=0, so IDLE performs a capture too.
    always_comb begin
        state_d   = state_q;
        t_d       = t_q;
        row_idx_d = row_idx_q;
        done_d    = 1'b0;
        cap_en    = 1'b0;
        cap_t     = t_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cap_en  = 1'b1;
                    cap_t   = '0;
                    t_d     = TW'(1);
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                cap_en = 1'b1;
                if (t_q == TLAST) begin
                    t_d       = '0;
                    row_idx_d = '0;
                    state_d   = DRAIN;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            DRAIN: begin
                if (row_ready) begin
                    if (row_idx_q == RLAST) begin
                        row_idx_d = '0;
                        done_d    = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        row_idx_d = row_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Lane c holds row t-c only while c <= t < N+c; outside that window it is ignored.
    always_comb begin
        for (int c = 0; c < ARRAY_SIZE; c++) begin
            lane_en[c]  = cap_en && (int'(cap_t) >= c) && (int'(cap_t) < ARRAY_SIZE + c);
            lane_row[c] = ARRAY_SIZE_WIDTH'(int'(cap_t) - c);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            t_q       <= '0;
            row_idx_q <= '0;
            done_q    <= 1'b0;
            for (int k = 0; k < ARRAY_SIZE; k++) begin
                for (int c = 0; c < ARRAY_SIZE; c++) begin
                    rowbuf_q[k][c] <= '0;
                end
            end
        end else begin
            state_q   <= state_d;
            t_q       <= t_d;
            row_idx_q <= row_idx_d;
            done_q    <= done_d;
            for (int c = 0; c < ARRAY_SIZE; c++) begin
                if (lane_en[c]) begin
                    rowbuf_q[lane_row[c]][c] <= results_in[c];
                end
            end
        end
    end

    always_comb begin
        for (int c = 0; c < ARRAY_SIZE; c++) begin
            row_data[c] = rowbuf_q[row_idx_q][c];
        end
    end

    assign row_idx   = row_idx_q;
    assign row_valid = (state_q == DRAIN);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule
